// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that gives one of three drawing engines the single VGA
// adapter pixel-write port. It forwards that engine's plots through one register stage and clips off-screen pixels.
module vga_plot_arbiter #(
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    output logic [2:0]  gnt,
    input  logic [23:0] in_x,
    input  logic [20:0] in_y,
    input  logic [8:0]  in_colour,
    input  logic [2:0]  in_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic [14:0] pix_count
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [14:0] PIX_MAX = 15'h7FFF;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_plot_q, vga_plot_d;
    logic [14:0] pix_count_q, pix_count_d;

    logic [7:0]  eng_x [3];
    logic [6:0]  eng_y [3];
    logic [2:0]  eng_c [3];
    logic [2:0]  eng_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign eng_x[gi] = in_x[8*gi +: 8];
            assign eng_y[gi] = in_y[7*gi +: 7];
            assign eng_c[gi] = in_colour[3*gi +: 3];
            assign eng_ok[gi] = in_plot[gi]
                             && ({24'd0, eng_x[gi]} < 32'(XMAX))
                             && ({25'd0, eng_y[gi]} < 32'(YMAX));
        end
    endgenerate

    // While granted, last_q is the granted index, so it doubles as the data mux select.
    logic       req_g;
    logic       ok_g;
    logic [7:0] x_g;
    logic [6:0] y_g;
    logic [2:0] c_g;

    always_comb begin
        req_g = 1'b0;
        ok_g  = 1'b0;
        x_g   = '0;
        y_g   = '0;
        c_g   = '0;
        for (int i = 0; i < 3; i++) begin
            if (last_q == 2'(i)) begin
                req_g = req[i];
                ok_g  = eng_ok[i] && gnt_q[i];
                x_g   = eng_x[i];
                y_g   = eng_y[i];
                c_g   = eng_c[i];
            end
        end
    end

    // Round-robin pick: first requester found searching upward from last_q + 1.
    logic [1:0] sel;
    logic       found;

    always_comb begin
        sel   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (!found && req[(int'(last_q) + k) % 3]) begin
                sel   = 2'((int'(last_q) + k) % 3);
                found = 1'b1;
            end
        end
    end

    logic fwd;
    assign fwd = (state_q == GRANT) && ok_g;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = fwd;
        pix_count_d  = pix_count_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    gnt_d       = 3'b001 << sel;
                    last_d      = sel;
                    pix_count_d = '0;
                end
            end
            GRANT: begin
                if (!req_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (fwd) begin
            vga_x_d      = x_g;
            vga_y_d      = y_g;
            vga_colour_d = c_g;
            if (pix_count_q != PIX_MAX) begin
                pix_count_d = pix_count_q + 15'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_q       <= 2'd2;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = |gnt_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign pix_count  = pix_count_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed-plus-random bench for vga_plot_arbiter, checked against a
// behavioural model of grant ownership, clipping and pixel counting.
module tb_vga_plot_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [23:0] in_x;
    logic [20:0] in_y;
    logic [8:0]  in_colour;
    logic [2:0]  in_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic [14:0] pix_count;

    vga_plot_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fwd_seen = 0;

    // Model: owner index (-1 = nobody), last owner, and the adapter-side view.
    int         m_g;
    int         m_last;
    int         m_cnt;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic       m_plot;

    int noise_en = 0;
    int drv = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_g = -1; m_last = 2; m_cnt = 0;
        m_x = 0; m_y = 0; m_c = 0; m_plot = 0;
    endtask

    task automatic m_step();
        int px, py;
        if (m_g < 0) begin
            m_plot = 0;
            if (req != 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_g < 0 && req[(m_last + k) % 3]) m_g = (m_last + k) % 3;
                end
                m_last = m_g;
                m_cnt = 0;
            end
        end else begin
            px = int'(in_x[8*m_g +: 8]);
            py = int'(in_y[7*m_g +: 7]);
            m_plot = in_plot[m_g] && px < 160 && py < 120;
            if (m_plot) begin
                m_x = in_x[8*m_g +: 8];
                m_y = in_y[7*m_g +: 7];
                m_c = in_colour[3*m_g +: 3];
                if (m_cnt < 32767) m_cnt++;
            end
            if (!req[m_g]) m_g = -1;
        end
    endtask

    task automatic compare_all();
        check("gnt", 32'(gnt), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
        check("busy", 32'(busy), 32'(m_g >= 0));
        check("vga_plot", 32'(vga_plot), 32'(m_plot));
        check("vga_x", 32'(vga_x), 32'(m_x));
        check("vga_y", 32'(vga_y), 32'(m_y));
        check("vga_colour", 32'(vga_colour), 32'(m_c));
        check("pix_count", 32'(pix_count), 32'(m_cnt));
    endtask

    task automatic cycle();
        if (noise_en != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (i != drv) begin
                    in_plot[i]           = 1'($urandom);
                    in_x[8*i +: 8]       = 8'($urandom);
                    in_y[7*i +: 7]       = 7'($urandom);
                    in_colour[3*i +: 3]  = 3'($urandom);
                end
            end
        end
        m_step();
        @(posedge clk);
        #1;
        if (vga_plot === 1'b1) fwd_seen++;
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_eng(input int e, input logic p, input logic [7:0] x,
                           input logic [6:0] y, input logic [2:0] c);
        in_plot[e]          = p;
        in_x[8*e +: 8]      = x;
        in_y[7*e +: 7]      = y;
        in_colour[3*e +: 3] = c;
    endtask

    initial begin
        int exp_order [4];
        int idx;
        exp_order = '{0, 1, 2, 0};
        req = 0; in_x = 0; in_y = 0; in_colour = 0; in_plot = 0;
        m_reset();

        // Reset state
        apply_reset();

        // Single job from engine 0, other engines chatter
        noise_en = 1; drv = 0;
        req = 3'b001;
        cycle();
        check("single_gnt", 32'(gnt), 32'b001);
        set_eng(0, 1'b1, 8'd5, 7'd7, 3'd3);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("single_plot", 32'(vga_plot), 32'd1);
        end
        set_eng(0, 1'b0, 8'd5, 7'd7, 3'd3);
        req = 3'b000;
        cycle();
        check("single_cnt", 32'(pix_count), 32'd4);
        check("single_release", 32'(gnt), 32'd0);
        check("single_busy", 32'(busy), 32'd0);
        cycle();

        // Round-robin under contention
        noise_en = 0;
        in_plot = 0;
        apply_reset();
        noise_en = 1; drv = 3;
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < 6 && gnt == 3'b000; w++) cycle();
            check("rr_granted", 32'(gnt != 3'b000), 32'd1);
            idx = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : (gnt == 3'b100) ? 2 : 3;
            check("rr_order", 32'(idx), 32'(exp_order[n]));
            cycle();
            if (idx < 3) req[idx] = 1'b0;
            cycle();
            check("rr_gap", 32'(gnt), 32'd0);
            req = 3'b111;
        end
        req = 3'b000;
        cycle();
        cycle();

        // Non-granted plot rejection
        noise_en = 0;
        in_plot = 0;
        req = 3'b001;
        cycle();
        check("rej_gnt", 32'(gnt), 32'b001);
        for (int i = 0; i < 4; i++) begin
            set_eng(1, 1'(i % 2 == 0), 8'd10, 7'($urandom_range(0, 119)), 3'($urandom));
            cycle();
            check("rej_plot", 32'(vga_plot), 32'd0);
        end
        set_eng(1, 1'b0, 8'd10, 7'd0, 3'd0);
        cycle();
        check("rej_cnt", 32'(pix_count), 32'd0);

        // Clipping
        set_eng(0, 1'b1, 8'd159, 7'd119, 3'd5); cycle();
        set_eng(0, 1'b1, 8'd160, 7'd0,   3'd6); cycle();
        check("clip_first", 32'(vga_plot), 32'd0);
        set_eng(0, 1'b1, 8'd0,   7'd120, 3'd1); cycle();
        set_eng(0, 1'b1, 8'd255, 7'd127, 3'd2); cycle();
        set_eng(0, 1'b0, 8'd0,   7'd0,   3'd0); cycle();
        check("clip_cnt", 32'(pix_count), 32'd1);
        check("clip_x", 32'(vga_x), 32'd159);
        check("clip_y", 32'(vga_y), 32'd119);

        // Reset mid-operation
        set_eng(0, 1'b1, 8'd20, 7'd30, 3'd4);
        cycle();
        apply_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_cnt", 32'(pix_count), 32'd0);
        set_eng(0, 1'b0, 8'd0, 7'd0, 3'd0);
        req = 3'b110;
        cycle();
        check("rst_regrant", 32'(gnt), 32'b010);

        // Saturation with engine 1
        noise_en = 1; drv = 1;
        fwd_seen = 0;
        for (int i = 0; i < 32770; i++) begin
            set_eng(1, 1'b1, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom));
            cycle();
        end
        set_eng(1, 1'b0, 8'd0, 7'd0, 3'd0);
        req = 3'b000;
        cycle();
        check("sat_cnt", 32'(pix_count), 32'd32767);
        check("sat_fwd", 32'(fwd_seen), 32'd32770);
        cycle();
        check("sat_hold", 32'(pix_count), 32'd32767);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
